// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two-source result FIFOs feeding one registered CDB broadcast.
// Ports: clk, rst (sync, active-low), rdy, rollback_flag; ALU_* and LSB_*
// result inputs with X_ready back-pressure; CDB_* registered broadcast.
// Optional macro CDB_FIXED_PRIO_EN: ALU always wins (default round-robin).
module cdb_arbiter #(
  parameter int QUEUE_DEPTH  = 2,
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback_flag,
  input  logic                    ALU_input_valid,
  input  logic [ROB_ID_WIDTH-1:0] ALU_ROB_id,
  input  logic [DATA_WIDTH-1:0]   ALU_value,
  input  logic [DATA_WIDTH-1:0]   ALU_targeted_pc,
  input  logic                    ALU_jump_flag,
  output logic                    ALU_ready,
  input  logic                    LSB_input_valid,
  input  logic [ROB_ID_WIDTH-1:0] LSB_ROB_id,
  input  logic [DATA_WIDTH-1:0]   LSB_value,
  output logic                    LSB_ready,
  output logic                    CDB_valid,
  output logic [ROB_ID_WIDTH-1:0] CDB_ROB_id,
  output logic [DATA_WIDTH-1:0]   CDB_value,
  output logic [DATA_WIDTH-1:0]   CDB_targeted_pc,
  output logic                    CDB_jump_flag,
  output logic                    CDB_src
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   value;
    logic [DATA_WIDTH-1:0]   pc;
    logic                    jump;
  } alu_ent_t;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   value;
  } lsb_ent_t;

  alu_ent_t alu_mem_q [QUEUE_DEPTH];
  alu_ent_t alu_mem_d [QUEUE_DEPTH];
  lsb_ent_t lsb_mem_q [QUEUE_DEPTH];
  lsb_ent_t lsb_mem_d [QUEUE_DEPTH];

  logic [PW-1:0] alu_rd_q, alu_rd_d;
  logic [PW-1:0] alu_wr_q, alu_wr_d;
  logic [CW-1:0] alu_cnt_q, alu_cnt_d;
  logic [PW-1:0] lsb_rd_q, lsb_rd_d;
  logic [PW-1:0] lsb_wr_q, lsb_wr_d;
  logic [CW-1:0] lsb_cnt_q, lsb_cnt_d;

  logic last_grant_q, last_grant_d;

  logic                    cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_WIDTH-1:0] cdb_id_q, cdb_id_d;
  logic [DATA_WIDTH-1:0]   cdb_value_q, cdb_value_d;
  logic [DATA_WIDTH-1:0]   cdb_pc_q, cdb_pc_d;
  logic                    cdb_jump_q, cdb_jump_d;
  logic                    cdb_src_q, cdb_src_d;

  logic active, flush;
  logic alu_ne, lsb_ne;
  logic gnt_alu, gnt_lsb;
  logic alu_push, lsb_push;
  logic alu_pop, lsb_pop;

  assign active = rdy & ~rollback_flag;
  assign flush  = rdy & rollback_flag;

  assign ALU_ready = active & (alu_cnt_q != FULL);
  assign LSB_ready = active & (lsb_cnt_q != FULL);

  assign alu_push = ALU_input_valid & ALU_ready;
  assign lsb_push = LSB_input_valid & LSB_ready;

  assign alu_ne = |alu_cnt_q;
  assign lsb_ne = |lsb_cnt_q;

`ifdef CDB_FIXED_PRIO_EN
  assign gnt_alu = alu_ne;
  assign gnt_lsb = lsb_ne & ~alu_ne;
`else
  // last_grant_q=1 means LSB went last, so ALU gets the tie.
  assign gnt_alu = alu_ne & (~lsb_ne | last_grant_q);
  assign gnt_lsb = lsb_ne & (~alu_ne | ~last_grant_q);
`endif

  assign alu_pop = active & gnt_alu;
  assign lsb_pop = active & gnt_lsb;

  always_comb begin
    alu_mem_d    = alu_mem_q;
    lsb_mem_d    = lsb_mem_q;
    alu_rd_d     = alu_rd_q;
    alu_wr_d     = alu_wr_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_rd_d     = lsb_rd_q;
    lsb_wr_d     = lsb_wr_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_id_d     = cdb_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_pc_d     = cdb_pc_q;
    cdb_jump_d   = cdb_jump_q;
    cdb_src_d    = cdb_src_q;

    if (flush) begin
      alu_rd_d    = '0;
      alu_wr_d    = '0;
      alu_cnt_d   = '0;
      lsb_rd_d    = '0;
      lsb_wr_d    = '0;
      lsb_cnt_d   = '0;
      cdb_valid_d = 1'b0;
    end else if (active) begin
      unique case (1'b1)
        gnt_alu: begin
          cdb_valid_d  = 1'b1;
          cdb_id_d     = alu_mem_q[alu_rd_q].id;
          cdb_value_d  = alu_mem_q[alu_rd_q].value;
          cdb_pc_d     = alu_mem_q[alu_rd_q].pc;
          cdb_jump_d   = alu_mem_q[alu_rd_q].jump;
          cdb_src_d    = 1'b0;
          alu_rd_d     = alu_rd_q + PW'(1);
          last_grant_d = 1'b0;
        end
        gnt_lsb: begin
          cdb_valid_d  = 1'b1;
          cdb_id_d     = lsb_mem_q[lsb_rd_q].id;
          cdb_value_d  = lsb_mem_q[lsb_rd_q].value;
          cdb_pc_d     = '0;
          cdb_jump_d   = 1'b0;
          cdb_src_d    = 1'b1;
          lsb_rd_d     = lsb_rd_q + PW'(1);
          last_grant_d = 1'b1;
        end
        default: cdb_valid_d = 1'b0;
      endcase

      if (alu_push) begin
        alu_mem_d[alu_wr_q] = '{
          id:    ALU_ROB_id,
          value: ALU_value,
          pc:    ALU_targeted_pc,
          jump:  ALU_jump_flag
        };
        alu_wr_d = alu_wr_q + PW'(1);
      end
      if (lsb_push) begin
        lsb_mem_d[lsb_wr_q] = '{
          id:    LSB_ROB_id,
          value: LSB_value
        };
        lsb_wr_d = lsb_wr_q + PW'(1);
      end

      alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(alu_pop);
      lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(lsb_pop);
    end
  end

  always_ff @(posedge clk) begin
    alu_mem_q <= alu_mem_d;
    lsb_mem_q <= lsb_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_rd_q     <= '0;
      alu_wr_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      cdb_valid_q  <= 1'b0;
      cdb_id_q     <= '0;
      cdb_value_q  <= '0;
      cdb_pc_q     <= '0;
      cdb_jump_q   <= 1'b0;
      cdb_src_q    <= 1'b0;
    end else begin
      alu_rd_q     <= alu_rd_d;
      alu_wr_q     <= alu_wr_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_rd_q     <= lsb_rd_d;
      lsb_wr_q     <= lsb_wr_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_id_q     <= cdb_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_pc_q     <= cdb_pc_d;
      cdb_jump_q   <= cdb_jump_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign CDB_valid       = cdb_valid_q;
  assign CDB_ROB_id      = cdb_id_q;
  assign CDB_value       = cdb_value_q;
  assign CDB_targeted_pc = cdb_pc_q;
  assign CDB_jump_flag   = cdb_jump_q;
  assign CDB_src         = cdb_src_q;

endmodule
